// File: rtl/mult_seq.sv
// Sequential radix-2 shift-and-add multiplier (signed/unsigned) with a start/valid
// handshake; one full-width product every B_WIDTH+2 cycles.
module mult_seq #(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 32,
    parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic               signed_mode,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic               busy,
    output logic [P_WIDTH-1:0] product,
    output logic               valid_out
);

    localparam int CNT_W = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOOP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [P_WIDTH-1:0]   r_ma;
    logic [B_WIDTH-1:0]   r_mb;
    logic [P_WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_count;
    logic                 r_neg;
    logic [P_WIDTH-1:0]   r_product;
    logic                 r_valid_out;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [A_WIDTH-1:0]   w_a_mag;
    logic [B_WIDTH-1:0]   w_b_mag;
    logic [P_WIDTH-1:0]   w_acc_sum;

    // Two's-complement sign application for the final product; -0 is naturally 0.
    function automatic logic [P_WIDTH-1:0] f_apply_sign(input logic [P_WIDTH-1:0] mag,
                                                        input logic neg);
        return neg ? -mag : mag;
    endfunction

    // The most negative operand negates to itself, which is its correct unsigned magnitude.
    assign w_sign_a  = signed_mode & a[A_WIDTH-1];
    assign w_sign_b  = signed_mode & b[B_WIDTH-1];
    assign w_a_mag   = w_sign_a ? -a : a;
    assign w_b_mag   = w_sign_b ? -b : b;

    assign w_accept  = (r_state == S_IDLE) && valid_in;
    assign w_last    = (r_state == S_LOOP) && (r_count == CNT_W'(B_WIDTH - 1));
    assign w_acc_sum = r_acc + (r_mb[0] ? r_ma : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (valid_in) w_state_next = S_LOOP;
            S_LOOP:  if (w_last)   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    // The final iteration's sum is folded straight into product so valid_out
    // lands in the DONE cycle while staying a registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ma        <= '0;
            r_mb        <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_neg       <= 1'b0;
            r_product   <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            if (w_accept) begin
                r_neg   <= w_sign_a ^ w_sign_b;
                r_ma    <= {{(P_WIDTH - A_WIDTH){1'b0}}, w_a_mag};
                r_mb    <= w_b_mag;
                r_acc   <= '0;
                r_count <= '0;
            end else if (r_state == S_LOOP) begin
                r_acc   <= w_acc_sum;
                r_ma    <= r_ma << 1;
                r_mb    <= r_mb >> 1;
                r_count <= r_count + CNT_W'(1);
                if (w_last) begin
                    r_product   <= f_apply_sign(w_acc_sum, r_neg);
                    r_valid_out <= 1'b1;
                end
            end
        end
    end

    assign product   = r_product;
    assign valid_out = r_valid_out;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed corner cases, handshake, reset
// behaviour and randomized operands against an arithmetic reference model.
module tb_mult_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        signed_mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [63:0] product;
    logic        valid_out;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] last_prod = '0;

    mult_seq dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .product     (product),
        .valid_out   (valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic sm, input logic [31:0] x,
                                            input logic [31:0] y);
        longint sx;
        longint sy;
        if (sm) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, want 0x%h", tag, obs, exp);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of cycle T+34.
    task automatic do_mult(input logic sm, input logic [31:0] xa, input logic [31:0] xb,
                           input bit keep_valid);
        logic [63:0] exp;
        int          busy_n;
        int          vld_n;
        int          vld_at;
        bit          held;
        exp         = ref_mul(sm, xa, xb);
        signed_mode = sm;
        a           = xa;
        b           = xb;
        valid_in    = 1'b1;
        busy_n      = 0;
        vld_n       = 0;
        vld_at      = 0;
        held        = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            valid_in    = keep_valid;
            a           = $urandom;
            b           = $urandom;
            signed_mode = 1'($urandom_range(0, 1));
            if (busy) busy_n++;
            if (valid_out) begin
                vld_n++;
                vld_at = k;
            end
            if (k < 33 && product !== last_prod) held = 1'b0;
            if (k == 34 && product !== exp) held = 1'b0;
            if (k == 33) check("product", product, exp);
        end
        check("busy_len", 64'(busy_n), 64'd33);
        check("vld_pulses", 64'(vld_n), 64'd1);
        check("vld_cycle", 64'(vld_at), 64'd33);
        check("hold", 64'(held), 64'd1);
        last_prod = exp;
    endtask

    initial begin
        int          n_vld;
        logic [31:0] ra;
        logic [31:0] rb;

        reset       = 1'b1;
        valid_in    = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_vld", 64'(valid_out), 64'd0);
        check("rst_product", product, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("umax_const", last_prod, 64'hFFFF_FFFE_0000_0001);
        do_mult(1'b1, 32'hFFFF_FFF9, 32'd6, 1'b0);
        check("neg42_const", last_prod, 64'hFFFF_FFFF_FFFF_FFD6);
        do_mult(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b0);
        do_mult(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_mult(1'b1, 32'h8000_0000, 32'd1, 1'b0);
        do_mult(1'b1, 32'd0, 32'hFFFF_FFFB, 1'b0);
        do_mult(1'b0, 32'd1, 32'd1, 1'b0);

        // valid_in held high with operands churning every cycle
        for (int i = 0; i < 4; i++) begin
            do_mult(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b1);
        end
        do_mult(1'b1, 32'h1234_5678, 32'h8765_4321, 1'b0);

        // Reset in the middle of LOOP
        signed_mode = 1'b0;
        a           = 32'd3;
        b           = 32'd5;
        valid_in    = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_product", product, 64'd0);
        check("midrst_vld", 64'(valid_out), 64'd0);
        reset = 1'b0;
        n_vld = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_out) n_vld++;
        end
        check("midrst_no_vld", 64'(n_vld), 64'd0);
        last_prod = '0;
        do_mult(1'b0, 32'd3, 32'd5, 1'b0);
        check("after_rst_15", last_prod, 64'd15);

        // Reset and valid_in together: nothing accepted
        reset    = 1'b1;
        valid_in = 1'b1;
        a        = 32'd7;
        b        = 32'd7;
        @(negedge clk);
        reset    = 1'b0;
        valid_in = 1'b0;
        check("rst_vs_vld_busy", 64'(busy), 64'd0);
        check("rst_vs_vld_product", product, 64'd0);
        @(negedge clk);
        check("rst_vs_vld_busy2", 64'(busy), 64'd0);
        last_prod = '0;

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: ra = '0;
                default: ;
            endcase
            do_mult(1'($urandom_range(0, 1)), ra, rb,
                    (i < 15) ? bit'($urandom_range(0, 1)) : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
# mult_seq

Sequential radix-2 shift-and-add multiplier, signed or unsigned, sharing the start/valid handshake of the team's iterative divider. It forms full-width products for the FM radio datapath (gain scaling, quotient-times-divisor reconstruction) where a DSP-block multiplier is not wanted. Throughput is one product per B_WIDTH+2 cycles. Operands are latched at accept, so upstream may change inputs freely while the block is busy.

## Interface

- A_WIDTH, 32, width of multiplicand `a`
- B_WIDTH, 32, width of multiplier `b`; equals the iteration count
- P_WIDTH, A_WIDTH+B_WIDTH, product width (derived; not overridden)

- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- valid_in  in  1  start request; honoured only when busy=0
- signed_mode  in  1  1: a and b are two's-complement; 0: unsigned; latched at accept
- a  in  A_WIDTH  multiplicand, latched at accept
- b  in  B_WIDTH  multiplier, latched at accept
- busy  out  1  high from the cycle after accept through the valid_out cycle
- product  out  P_WIDTH  result; registered and held until the next valid_out
- valid_out  out  1  one-cycle pulse; product is valid in the same cycle

## Operation

- Reset: state=IDLE; product=0, valid_out=0, busy=0; all internal registers cleared.
- State IDLE:
  - valid_in=1 is an accept.
  - On accept, capture sign_a, sign_b and neg=sign_a^sign_b (forced to 0 when signed_mode=0).
  - Capture magnitudes: ma=|a| zero-extended to P_WIDTH, mb=|b|, and clear acc and count.
  - Go to LOOP.
  - In signed mode, the most negative value (e.g. -2^31) has magnitude 2^(W-1), which fits unsigned W bits. No special case is needed.
- State LOOP, one iteration per cycle:
  - If mb[0], acc <= acc + ma.
  - Then ma <= ma<<1, mb <= mb>>1, count <= count+1.
  - After B_WIDTH iterations (count reaches B_WIDTH-1 in the current cycle), go to DONE.
  - There is no early exit. Latency is data-independent.
- State DONE:
  - product <= neg ? -acc : acc (P_WIDTH two's complement).
  - valid_out <= 1 for exactly one cycle, then return to IDLE.
- Width rules:
  - The product always fits P_WIDTH. Signed extreme: (-2^31)·(-2^31)=2^62 < 2^63. Unsigned extreme: (2^32-1)^2 < 2^64.
  - There is no overflow output.
  - acc additions are P_WIDTH, modulo, and never wrap for legal operands.
- Zero result with neg=1: negation of 0 yields 0. product is never "-0" and no special case is needed.
- valid_in while busy=1 is ignored and not queued. Latched operands are unaffected.
- Changes to a, b or signed_mode after accept have no effect on the result in progress.

## Timing

- Accept in cycle T means valid_in=1 and busy=0 sampled at the rising edge ending cycle T.
- busy=1 during cycles T+1 … T+B_WIDTH+1.
- LOOP occupies cycles T+1 … T+B_WIDTH.
- valid_out=1 and the new product appear in cycle T+B_WIDTH+1.
- busy=0 again in cycle T+B_WIDTH+2, which is the earliest next accept.
- Back-to-back throughput: one result per B_WIDTH+2 cycles (34 at default widths).
- product is stable between valid_out pulses. It changes only in a valid_out cycle or on reset.
- Reset asserted mid-operation (any state): on the next edge, go to IDLE with outputs at their reset values. The in-flight result is discarded and no valid_out is produced.
- Reset and valid_in in the same cycle: reset wins and nothing is accepted.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan

- Unsigned: signed_mode=0, a=0xFFFF_FFFF, b=0xFFFF_FFFF → at T+33, valid_out=1 and product=0xFFFF_FFFE_0000_0001. busy is high for exactly 33 cycles.
- Signed mix: signed_mode=1, a=-7 (0xFFFF_FFF9), b=6 → product=0xFFFF_FFFF_FFFF_FFD6 (-42). Also a=-7, b=-6 → 42.
- Signed extremes: a=b=0x8000_0000 with signed_mode=1 → 0x4000_0000_0000_0000. a=0x8000_0000, b=1 → 0xFFFF_FFFF_8000_0000.
- Zero/sign: a=0, b=-5 signed → product=0. a=1, b=1 → 1. Throughout, valid_out is a single-cycle pulse.
- Handshake: assert valid_in continuously with operands changing every cycle. Required results:
  - Accepts occur only at T and T+34.
  - Each result uses the operands sampled at its own accept.
  - product holds between pulses.
- Reset mid-LOOP: accept a=3, b=5, then assert reset at T+10 for one cycle. Required results:
  - The next cycle shows busy=0 and product=0, and no valid_out follows.
  - A new accept then gives 15 at its own T+33.
